mdc_commutator: RTL and testbench
=================================

MDC_COMMUTATOR -- requirements
Module: mdc_commutator

Interface
REQ-001 SHALL have parameter LOGQ, default 0 (must be overridden), meaning coefficient width in bits.
REQ-002 SHALL have parameter DEPTH, default 1, meaning commutator delay D in pairs; must be a power of two, at least 1.
REQ-003 SHALL have parameter LOGD, default 1, equal to max(1, log2(DEPTH)), meaning the index counter width.
REQ-004 SHALL have one clock and one reset, with reset synchronous and active-high; the ports are named clk and rst.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input pair is accepted this cycle.
REQ-008 in_a  input  LOGQ  upper-lane coefficient.
REQ-009 in_b  input  LOGQ  lower-lane coefficient.
REQ-010 out_valid  output  1  output pair is valid, registered.
REQ-011 out_a  output  LOGQ  butterfly operand A, registered.
REQ-012 out_b  output  LOGQ  butterfly operand B, registered.
REQ-013 out_idx  output  LOGD  position m within the current D-block, for twiddle addressing; registered.

Function
REQ-014 SHALL number accepted pairs k = 0, 1, 2, ... since reset; internal state advances only on cycles with in_valid=1 (stall-tolerant).
REQ-015 SHALL, on accepting pair k with k >= D and (k/D) odd, register out_a=a[k-D] and out_b=a[k] at the next edge.
REQ-016 SHALL, on accepting pair k with k >= 2D and (k/D) even, register out_a=b[k-2D] and out_b=b[k-D] at the next edge.
REQ-017 SHALL set out_valid=1 exactly one clock after each accepting cycle with k >= D, and 0 otherwise.
REQ-018 SHALL hold out_a, out_b and out_idx stable while out_valid=0.
REQ-019 SHALL set out_idx = k mod D of the pair that produced the output.
REQ-020 SHALL produce no output for k in [0,D), the priming phase; out_valid stays 0 there.
REQ-021 SHALL wrap the pair counter modulo 2D without changing behaviour; the primed flag is sticky until reset.
REQ-022 SHALL implement lane B through a D-deep enabled delay, a swap switch selected by counter bit LOGD (k/D odd = pass, even = swap), and a D-deep enabled delay on the upper switch output.
REQ-023 SHALL for DEPTH=1 degenerate to single registers, with out_idx constant 0.
REQ-024 SHALL be purely data-moving: no arithmetic, and widths are preserved at LOGQ.
REQ-025 SHALL give rst priority over a simultaneous in_valid=1; the pair is dropped.

Reset
REQ-026 SHALL on rst clear out_valid, out_a, out_b, out_idx, the pair counter and the primed flag to 0 on the same edge.
REQ-027 SHALL not require delay-line contents to be cleared; stale data must never be emitted, which the primed gating guarantees.
REQ-028 SHALL, on reset mid-stream, restart at k=0 with a full new priming phase of D accepted pairs.

Structure
REQ-029 SHALL take LOGQ and the DEPTH/LOGD derivation helper from the shared NTT parameter/defines file used by the butterfly stages; no module-local constants beyond the localparams.
REQ-030 SHALL instantiate one sub-module, shiftreg_en: a parametric depth/width shift register with a shift-enable, used twice.
REQ-031 SHALL connect out_a, out_b and out_valid directly to the downstream butterfly's A/B inputs with no further glue; out_idx drives its twiddle ROM address.

Verification
REQ-032 D=2, in_valid=1 continuously, a[k]=k, b[k]=100+k for k=0..7 -> out at cycles 3..8: (0,2),(1,3),(100,102),(101,103),(4,6),(5,7); out_idx 0,1,0,1,0,1.
REQ-033 Same as REQ-032 with in_valid deasserted every other cycle -> identical output sequence; out_valid only one clock after accepting cycles; outputs held while gaps occur.
REQ-034 D=1, a[k]=k, b[k]=50+k for k=0..4 -> outputs (0,1),(50,51),(2,3),(52,53); out_idx always 0.
REQ-035 D=4, rst asserted together with in_valid at k=5 -> out_valid=0 next cycle; next four pairs produce no output; fifth pair yields (a0',a4') of the new stream.
REQ-036 D=8, LOGQ=32, 4096 random pairs vs. the REQ-015/016 golden model -> zero mismatches, including across counter wrap.

Source files
------------

// File: rtl/mdc_commutator_pkg.sv
// Shared NTT parameters and derivation helpers used by the butterfly pipeline stages.
package mdc_commutator_pkg;

  localparam int NTT_LOGQ = 32;

  // Index counter width: log2 of the commutator depth, but never narrower than one bit.
  function automatic int calc_logd(input int depth);
    int l;
    l = $clog2(depth);
    return (l < 1) ? 1 : l;
  endfunction

endpackage

// File: rtl/mdc_commutator_if.sv
// Pair stream into the commutator and butterfly-operand stream out of it.
interface mdc_commutator_if
  import mdc_commutator_pkg::*;
#(
  parameter int LOGQ = NTT_LOGQ,
  parameter int LOGD = 1
);

  logic            in_valid;
  logic [LOGQ-1:0] in_a;
  logic [LOGQ-1:0] in_b;
  logic            out_valid;
  logic [LOGQ-1:0] out_a;
  logic [LOGQ-1:0] out_b;
  logic [LOGD-1:0] out_idx;

  modport master (
    output in_valid, in_a, in_b,
    input  out_valid, out_a, out_b, out_idx
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output out_valid, out_a, out_b, out_idx
  );

endinterface

// File: rtl/mdc_commutator_shiftreg_en.sv
// Fixed-depth delay line that only advances on enabled cycles; contents are never reset.
module shiftreg_en #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mdc_commutator.sv
// Multi-path delay commutator: reorders two coefficient lanes into butterfly operand pairs
// spaced DEPTH apart, with the in-block position for twiddle addressing.
module mdc_commutator
  import mdc_commutator_pkg::*;
#(
  parameter int LOGQ  = 0,
  parameter int DEPTH = 1,
  parameter int LOGD  = calc_logd(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  mdc_commutator_if.slave    bus
);

  // Counter spans two D-blocks; its top bit tells which half of the period we are in.
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   idx_full;
  logic            primed;
  logic            odd_block;
  logic            shift;
  logic [LOGQ-1:0] b_delayed;
  logic [LOGQ-1:0] upper;
  logic [LOGQ-1:0] lower;
  logic [LOGQ-1:0] upper_delayed;
  logic            valid_q;
  logic [LOGQ-1:0] a_q;
  logic [LOGQ-1:0] b_q;
  logic [LOGD-1:0] idx_q;

  assign shift     = bus.in_valid & ~rst;
  assign odd_block = cnt[CW-1];
  assign idx_full  = cnt & CW'(DEPTH - 1);

  shiftreg_en #(.WIDTH(LOGQ), .DEPTH(DEPTH)) lane_b_delay (
    .clk  (clk),
    .en   (shift),
    .din  (bus.in_b),
    .dout (b_delayed)
  );

  // Odd blocks route the delayed B lane up and A straight down; even blocks the reverse.
  always_comb begin
    upper = bus.in_a;
    lower = b_delayed;
    if (odd_block) begin
      upper = b_delayed;
      lower = bus.in_a;
    end
  end

  shiftreg_en #(.WIDTH(LOGQ), .DEPTH(DEPTH)) upper_delay (
    .clk  (clk),
    .en   (shift),
    .din  (upper),
    .dout (upper_delayed)
  );

  // Outputs only update on productive cycles, so they hold through stalls and priming.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      primed  <= 1'b0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.in_valid) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(DEPTH - 1)) begin
          primed <= 1'b1;
        end
        if (primed) begin
          valid_q <= 1'b1;
          a_q     <= upper_delayed;
          b_q     <= lower;
          idx_q   <= LOGD'(idx_full);
        end
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_idx   = idx_q;

endmodule

// File: tb/tb_mdc_commutator.sv
// Bench for mdc_commutator: literal D=2 and D=1 sequences plus a D=8 randomized stream
// checked every cycle against a history-based model of the pairing rules.
module tb_mdc_commutator;
  import mdc_commutator_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_dir;
  logic rst8;

  mdc_commutator_if #(.LOGQ(16), .LOGD(1)) bus2 ();
  mdc_commutator_if #(.LOGQ(16), .LOGD(1)) bus1 ();
  mdc_commutator_if #(.LOGQ(32), .LOGD(3)) bus8 ();

  mdc_commutator #(.LOGQ(16), .DEPTH(2)) u2 (.clk(clk), .rst(rst_dir), .bus(bus2));
  mdc_commutator #(.LOGQ(16), .DEPTH(1)) u1 (.clk(clk), .rst(rst_dir), .bus(bus1));
  mdc_commutator #(.LOGQ(32), .DEPTH(8)) u8 (.clk(clk), .rst(rst8),    .bus(bus8));

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Directed D=2 / D=1 capture: valid outputs are queued, idle cycles must hold the last value.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        idx;
  } pair_t;

  pair_t q2[$];
  pair_t q1[$];
  pair_t last2, last1;
  bit    have2, have1;
  bit    collect = 1'b0;

  always @(negedge clk) begin
    if (collect) begin
      if (bus2.out_valid) begin
        last2 = '{bus2.out_a, bus2.out_b, bus2.out_idx};
        q2.push_back(last2);
        have2 = 1'b1;
      end else if (have2) begin
        check_output("hold_d2", 96'({bus2.out_a, bus2.out_b, bus2.out_idx}), 96'(last2));
      end
      if (bus1.out_valid) begin
        last1 = '{bus1.out_a, bus1.out_b, bus1.out_idx};
        q1.push_back(last1);
        have1 = 1'b1;
      end else if (have1) begin
        check_output("hold_d1", 96'({bus1.out_a, bus1.out_b, bus1.out_idx}), 96'(last1));
      end
    end
  end

  // D=8 model: keeps every accepted pair since reset and applies the pairing rules directly.
  localparam int D8 = 8;
  int          k8;
  logic [31:0] ah[$];
  logic [31:0] bh[$];
  logic        exp_v;
  logic [31:0] exp_a, exp_b;
  logic [2:0]  exp_idx;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (rst8) begin
      k8 = 0;
      ah.delete();
      bh.delete();
      exp_v = 1'b0; exp_a = '0; exp_b = '0; exp_idx = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      exp_v = 1'b0;
      if (bus8.in_valid) begin
        ah.push_back(bus8.in_a);
        bh.push_back(bus8.in_b);
        if (k8 >= D8) begin
          exp_v   = 1'b1;
          exp_idx = 3'(k8 % D8);
          if (((k8 / D8) % 2) == 1) begin
            exp_a = ah[k8 - D8];
            exp_b = ah[k8];
          end else begin
            exp_a = bh[k8 - 2*D8];
            exp_b = bh[k8 - D8];
          end
        end
        k8++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_output("stream_d8", 96'({bus8.out_valid, bus8.out_a, bus8.out_b, bus8.out_idx}),
                   96'({exp_v, exp_a, exp_b, exp_idx}));
    end
  end

  task automatic apply_dir(input bit v, input int k);
    bus2.in_valid = v;
    bus2.in_a     = 16'(k);
    bus2.in_b     = 16'(100 + k);
    bus1.in_valid = v;
    bus1.in_a     = 16'(k);
    bus1.in_b     = 16'(50 + k);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] b, input bit r);
    bus8.in_valid = v;
    bus8.in_a     = a;
    bus8.in_b     = b;
    rst8          = r;
    @(negedge clk);
  endtask

  task automatic run_directed(input bit gaps, input string tag);
    logic [15:0] ea2 [6];
    logic [15:0] eb2 [6];
    logic [15:0] ea1 [4];
    logic [15:0] eb1 [4];
    ea2 = '{16'd0, 16'd1, 16'd100, 16'd101, 16'd4, 16'd5};
    eb2 = '{16'd2, 16'd3, 16'd102, 16'd103, 16'd6, 16'd7};
    ea1 = '{16'd0, 16'd50, 16'd2, 16'd52};
    eb1 = '{16'd1, 16'd51, 16'd3, 16'd53};
    collect = 1'b0;
    rst_dir = 1'b1;
    apply_dir(1'b1, 77);
    rst_dir = 1'b0;
    q2.delete();
    q1.delete();
    have2 = 1'b0;
    have1 = 1'b0;
    collect = 1'b1;
    for (int k = 0; k < 8; k++) begin
      apply_dir(1'b1, k);
      if (gaps) apply_dir(1'b0, k + 200);
    end
    for (int i = 0; i < 3; i++) apply_dir(1'b0, 300);
    collect = 1'b0;
    check_output({tag, "_count_d2"}, 96'(q2.size()), 96'd6);
    check_output({tag, "_count_d1"}, 96'(q1.size()), 96'd7);
    for (int i = 0; i < 6; i++) begin
      if (i < q2.size())
        check_output({tag, "_pair_d2"}, 96'(q2[i]), 96'({ea2[i], eb2[i], 1'(i % 2)}));
    end
    for (int i = 0; i < 4; i++) begin
      if (i < q1.size())
        check_output({tag, "_pair_d1"}, 96'(q1[i]), 96'({ea1[i], eb1[i], 1'b0}));
    end
  endtask

  int accepted;
  bit v;

  initial begin
    rst_dir = 1'b1;
    rst8    = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
    @(negedge clk);
    @(negedge clk);
    check_output("reset_d8", 96'({bus8.out_valid, bus8.out_a, bus8.out_b, bus8.out_idx}), 96'd0);
    check_output("reset_d2", 96'({bus2.out_valid, bus2.out_a, bus2.out_b, bus2.out_idx}), 96'd0);
    rst8 = 1'b0;

    run_directed(1'b0, "cont");
    run_directed(1'b1, "gap");

    // Known-value prefix for D=8 pins both the model and the DUT.
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, 32'(k), 32'(1000 + k), 1'b0);
      if (k == 7) begin
        check_output("model_k7", 96'(exp_v), 96'd0);
        check_output("dut_k7", 96'(bus8.out_valid), 96'd0);
      end
      if (k == 8) begin
        check_output("model_k8", 96'({exp_v, exp_a, exp_b, exp_idx}), 96'({1'b1, 32'd0, 32'd8, 3'd0}));
        check_output("dut_k8", 96'({bus8.out_a, bus8.out_b, bus8.out_idx}), 96'({32'd0, 32'd8, 3'd0}));
      end
      if (k == 13)
        check_output("model_k13", 96'({exp_v, exp_a, exp_b, exp_idx}), 96'({1'b1, 32'd5, 32'd13, 3'd5}));
      if (k == 16)
        check_output("model_k16", 96'({exp_v, exp_a, exp_b, exp_idx}), 96'({1'b1, 32'd1000, 32'd1008, 3'd0}));
      if (k == 23)
        check_output("dut_k23", 96'({bus8.out_a, bus8.out_b, bus8.out_idx}), 96'({32'd1007, 32'd1015, 3'd7}));
    end
    accepted = 24;

    for (int n = 0; accepted < 4096 && n < 20000; n++) begin
      if (n == 1500) begin
        applyStimulus(1'b1, $urandom, $urandom, 1'b1);
        check_output("midreset_valid", 96'(bus8.out_valid), 96'd0);
        check_output("midreset_model", 96'(exp_v), 96'd0);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        applyStimulus(v, $urandom, $urandom, 1'b0);
        if (v) accepted++;
      end
    end
    check_output("accepted_d8", 96'(accepted), 96'd4096);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, $urandom, $urandom, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
